// File: rtl/emc_xmc_pkg.sv
// emc_xmc_pkg: shared types for the EMC08 external code-memory controller.
// FSM/owner encodings and default parameter values.
package emc_xmc_pkg;

  localparam int ADDR_W_DEF       = 16;
  localparam int DATA_W_DEF       = 8;
  localparam int WAIT_STATES_DEF  = 1;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_READ
  } xmc_state_e;

  typedef enum logic {
    OWN_FETCH,
    OWN_MOVC
  } xmc_owner_e;

endpackage

// File: rtl/emc_xmc_arb.sv
// emc_xmc_arb: fetch/MOVC fixed-priority arbiter, active only while idle.
// EMC_XMC_STARVE_GUARD_EN adds a counter that lets MOVC past a fetch stream.
import emc_xmc_pkg::*;

module emc_xmc_arb #(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       fetch_req,
  input  logic       movc_req,
  output logic [1:0] gnt,
  output xmc_owner_e owner
);

  logic starve;
  logic sel_f;
  logic sel_m;

`ifdef EMC_XMC_STARVE_GUARD_EN
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0] cnt_q;

  assign starve = (cnt_q == LIM) && fetch_req && movc_req;

  // Count fetch wins while MOVC is kept waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!movc_req || gnt[1]) begin
      cnt_q <= '0;
    end else if (gnt[0]) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end
`else
  logic unused_ok;

  assign unused_ok = ^{clk, rst_n, 4'(STARVE_LIMIT)};
  assign starve    = 1'b0;
`endif

  assign sel_m = starve || (movc_req && !fetch_req);
  assign sel_f = fetch_req && !starve;

  // One-hot grant while the bus is idle.
  always_comb begin
    gnt   = 2'b00;
    owner = OWN_FETCH;
    if (en) begin
      unique case (1'b1)
        sel_f: begin
          gnt   = 2'b01;
          owner = OWN_FETCH;
        end
        sel_m: begin
          gnt   = 2'b10;
          owner = OWN_MOVC;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/emc_xmc_ctrl.sv
// emc_xmc_ctrl: external ROM read sequencer for fetch and MOVC ports.
// Optional EMC_XMC_STARVE_GUARD_EN enables the MOVC starvation guard.
import emc_xmc_pkg::*;

module emc_xmc_ctrl #(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int WAIT_STATES  = WAIT_STATES_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              xmc_clock_i,
  input  logic              xmc_reset_i,
  input  logic              xmc_fetch_req_i,
  input  logic [ADDR_W-1:0] xmc_fetch_addr_i,
  output logic              xmc_fetch_gnt_o,
  input  logic              xmc_movc_req_i,
  input  logic [ADDR_W-1:0] xmc_movc_addr_i,
  output logic              xmc_movc_gnt_o,
  output logic [DATA_W-1:0] xmc_rdata_o,
  output logic              xmc_fetch_valid_o,
  output logic              xmc_movc_valid_o,
  output logic              xmc_busy_o,
  output logic [7:0]        xmc_addr_hi_o,
  output logic [7:0]        xmc_addr_lo_o,
  output logic              xmc_psen_b_o,
  output logic              xmc_oe_b_o,
  input  logic [DATA_W-1:0] xmc_data_i
);

  localparam logic [2:0] WLAST =
    3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  xmc_state_e        state_q;
  xmc_state_e        state_d;
  xmc_owner_e        owner_q;
  xmc_owner_e        owner;
  logic [1:0]        gnt;
  logic [2:0]        wcnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              fv_q;
  logic              mv_q;
  logic              psen_b;
  logic              oe_b;
  logic              busy;

  emc_xmc_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk      (xmc_clock_i),
    .rst_n    (xmc_reset_i),
    .en       (state_q == ST_IDLE),
    .fetch_req(xmc_fetch_req_i),
    .movc_req (xmc_movc_req_i),
    .gnt      (gnt),
    .owner    (owner)
  );

  // State register.
  always_ff @(posedge xmc_clock_i or negedge xmc_reset_i) begin
    if (!xmc_reset_i) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // Next state and pin drive from the current state.
  always_comb begin
    state_d = state_q;
    psen_b  = 1'b1;
    oe_b    = 1'b1;
    busy    = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (|gnt) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        psen_b  = 1'b0;
        state_d = (WAIT_STATES == 0) ? ST_READ : ST_WAIT;
      end
      ST_WAIT: begin
        psen_b = 1'b0;
        if (wcnt_q == WLAST) state_d = ST_READ;
      end
      ST_READ: begin
        psen_b  = 1'b0;
        oe_b    = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Wait-state counter, restarted in every address phase.
  always_ff @(posedge xmc_clock_i or negedge xmc_reset_i) begin
    if (!xmc_reset_i)            wcnt_q <= '0;
    else if (state_q == ST_ADDR) wcnt_q <= '0;
    else if (state_q == ST_WAIT) wcnt_q <= wcnt_q + 3'd1;
  end

  // Latch the granted address and owner; hold them while idle.
  always_ff @(posedge xmc_clock_i or negedge xmc_reset_i) begin
    if (!xmc_reset_i) begin
      addr_q  <= '0;
      owner_q <= OWN_FETCH;
    end else if (state_q == ST_IDLE && |gnt) begin
      addr_q  <= gnt[1] ? xmc_movc_addr_i : xmc_fetch_addr_i;
      owner_q <= owner;
    end
  end

  // Capture ROM data at the end of READ and pulse the owner's valid.
  always_ff @(posedge xmc_clock_i or negedge xmc_reset_i) begin
    if (!xmc_reset_i) begin
      rdata_q <= '0;
      fv_q    <= 1'b0;
      mv_q    <= 1'b0;
    end else begin
      fv_q <= (state_q == ST_READ) && (owner_q == OWN_FETCH);
      mv_q <= (state_q == ST_READ) && (owner_q == OWN_MOVC);
      if (state_q == ST_READ) rdata_q <= xmc_data_i;
    end
  end

  assign xmc_fetch_gnt_o   = gnt[0];
  assign xmc_movc_gnt_o    = gnt[1];
  assign xmc_rdata_o       = rdata_q;
  assign xmc_fetch_valid_o = fv_q;
  assign xmc_movc_valid_o  = mv_q;
  assign xmc_busy_o        = busy;
  assign xmc_addr_hi_o     = addr_q[ADDR_W-1 -: 8];
  assign xmc_addr_lo_o     = addr_q[7:0];
  assign xmc_psen_b_o      = psen_b;
  assign xmc_oe_b_o        = oe_b;

endmodule
